alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_issue_stage_if.sv | 37 +++
 rtl/alu_issue_decode.sv | 172 +++++++++++++++++
 rtl/alu_issue_stage.sv | 121 ++++++++++++
 tb/tb_alu_issue_stage.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU function codes, RV32I opcodes and
// immediate-extraction helpers.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_EQ    = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_PASS2 = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID/EX issue bus: instruction input handshake, flush, and the registered
// ALU operand/control output handshake. The issue stage is the master.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_func;
  logic [XLEN-1:0] alu_src1;
  logic [XLEN-1:0] alu_src2;
  logic            br_en;
  logic            br_inv;
  logic [4:0]      rd;
  logic            wb_en;
  logic            illegal;

  modport master (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    output in_ready, out_valid, alu_func, alu_src1, alu_src2, br_en, br_inv, rd,
           wb_en, illegal
  );

  modport slave (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    input  in_ready, out_valid, alu_func, alu_src1, alu_src2, br_en, br_inv, rd,
           wb_en, illegal
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Purely combinational RV32I decode into ALU function, operands, branch and
// writeback control. Illegal encodings collapse to an inert add of zeros.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic [3:0]      o_func,
  output logic [XLEN-1:0] o_src1,
  output logic [XLEN-1:0] o_src2,
  output logic            o_br_en,
  output logic            o_br_inv,
  output logic [4:0]      o_rd,
  output logic            o_wb_en,
  output logic            o_illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd_field;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt_imm;
  logic [XLEN-1:0] w_shamt_reg;
  logic [3:0]      w_func;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic            w_br_en;
  logic            w_br_inv;
  logic            w_has_rd;
  logic            w_illegal;

  assign w_opcode    = i_instr[6:0];
  assign w_funct3    = i_instr[14:12];
  assign w_funct7    = i_instr[31:25];
  assign w_rd_field  = i_instr[11:7];
  assign w_imm_i     = XLEN'($signed(imm_i(i_instr)));
  assign w_imm_s     = XLEN'($signed(imm_s(i_instr)));
  assign w_imm_u     = XLEN'($signed(imm_u(i_instr)));
  // Shift amounts are clipped to 5 bits so the ALU never sees an oversize shift
  assign w_shamt_imm = XLEN'(i_instr[24:20]);
  assign w_shamt_reg = XLEN'(i_rs2_data[4:0]);

  // Opcode/funct decode into raw fields plus an illegal flag
  always_comb begin
    w_func    = ALU_ADD;
    w_src1    = i_rs1_data;
    w_src2    = i_rs2_data;
    w_br_en   = 1'b0;
    w_br_inv  = 1'b0;
    w_has_rd  = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_has_rd = 1'b1;
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: w_func = ALU_ADD;
          {7'b0100000, 3'b000}: w_func = ALU_SUB;
          {7'b0000000, 3'b001}: begin w_func = ALU_SLL; w_src2 = w_shamt_reg; end
          {7'b0000000, 3'b010}: w_func = ALU_SLT;
          {7'b0000000, 3'b011}: w_func = ALU_SLTU;
          {7'b0000000, 3'b100}: w_func = ALU_XOR;
          {7'b0000000, 3'b101}: begin w_func = ALU_SRL; w_src2 = w_shamt_reg; end
          {7'b0000000, 3'b110}: w_func = ALU_OR;
          {7'b0000000, 3'b111}: w_func = ALU_AND;
          default:              w_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        w_has_rd = 1'b1;
        w_src2   = w_imm_i;
        case (w_funct3)
          3'b000:  w_func = ALU_ADD;
          3'b010:  w_func = ALU_SLT;
          3'b011:  w_func = ALU_SLTU;
          3'b100:  w_func = ALU_XOR;
          3'b110:  w_func = ALU_OR;
          3'b111:  w_func = ALU_AND;
          3'b001: begin
            w_func    = ALU_SLL;
            w_src2    = w_shamt_imm;
            w_illegal = i_instr[30];
          end
          3'b101: begin
            w_func    = ALU_SRL;
            w_src2    = w_shamt_imm;
            w_illegal = i_instr[30];
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        w_has_rd = 1'b1;
        w_func   = ALU_PASS2;
        w_src2   = w_imm_u;
      end
      OPC_AUIPC: begin
        w_has_rd = 1'b1;
        w_src1   = i_pc;
        w_src2   = w_imm_u;
      end
      OPC_JAL: begin
        w_has_rd = 1'b1;
        w_src1   = i_pc;
        w_src2   = XLEN'(4);
      end
      OPC_JALR: begin
        w_has_rd  = 1'b1;
        w_src1    = i_pc;
        w_src2    = XLEN'(4);
        w_illegal = (w_funct3 != 3'b000);
      end
      OPC_LOAD: begin
        w_has_rd = 1'b1;
        w_src2   = w_imm_i;
        case (w_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
          default:                                w_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_src2 = w_imm_s;
        case (w_funct3)
          3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
          default:                w_illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        w_br_en = 1'b1;
        case (w_funct3)
          3'b000:  begin w_func = ALU_EQ;   w_br_inv = 1'b0; end
          3'b001:  begin w_func = ALU_EQ;   w_br_inv = 1'b1; end
          3'b100:  begin w_func = ALU_SLT;  w_br_inv = 1'b0; end
          3'b101:  begin w_func = ALU_SLT;  w_br_inv = 1'b1; end
          3'b110:  begin w_func = ALU_SLTU; w_br_inv = 1'b0; end
          3'b111:  begin w_func = ALU_SLTU; w_br_inv = 1'b1; end
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Squash everything but the illegal flag for undecodable instructions
  always_comb begin
    if (w_illegal) begin
      o_func    = ALU_ADD;
      o_src1    = {XLEN{1'b0}};
      o_src2    = {XLEN{1'b0}};
      o_br_en   = 1'b0;
      o_br_inv  = 1'b0;
      o_illegal = 1'b1;
    end else begin
      o_func    = w_func;
      o_src1    = w_src1;
      o_src2    = w_src2;
      o_br_en   = w_br_en;
      o_br_inv  = w_br_inv;
      o_illegal = 1'b0;
    end
  end

  assign o_wb_en = w_has_rd && !w_illegal && (w_rd_field != 5'd0);
  assign o_rd    = o_wb_en ? w_rd_field : 5'd0;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes at acceptance and holds ALU fields for EX.
// Define ALU_ISSUE_SKID_EN to add a one-entry skid buffer behind a registered in_ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter logic [3:0] NOP_FUNC = ALU_ADD
) (
  input  logic              clk,
  input  logic              rstn,
  alu_issue_stage_if.master bus
);

  localparam int            FW          = 4 + 2 * XLEN + 9;
  localparam logic [FW-1:0] FIELDS_IDLE = {NOP_FUNC, {(FW - 4){1'b0}}};

  logic [3:0]      w_dec_func;
  logic [XLEN-1:0] w_dec_src1;
  logic [XLEN-1:0] w_dec_src2;
  logic            w_dec_br_en;
  logic            w_dec_br_inv;
  logic [4:0]      w_dec_rd;
  logic            w_dec_wb_en;
  logic            w_dec_illegal;
  logic [FW-1:0]   w_dec_fields;
  logic            w_accept;
  logic            r_out_valid;
  logic [FW-1:0]   r_out_fields;

  alu_issue_decode #(.XLEN(XLEN)) u_decode (
    .i_instr    (bus.in_instr),
    .i_pc       (bus.in_pc),
    .i_rs1_data (bus.in_rs1_data),
    .i_rs2_data (bus.in_rs2_data),
    .o_func     (w_dec_func),
    .o_src1     (w_dec_src1),
    .o_src2     (w_dec_src2),
    .o_br_en    (w_dec_br_en),
    .o_br_inv   (w_dec_br_inv),
    .o_rd       (w_dec_rd),
    .o_wb_en    (w_dec_wb_en),
    .o_illegal  (w_dec_illegal)
  );

  assign w_dec_fields = {w_dec_func, w_dec_src1, w_dec_src2, w_dec_br_en, w_dec_br_inv,
                         w_dec_rd, w_dec_wb_en, w_dec_illegal};
  assign w_accept     = bus.in_valid && bus.in_ready;

`ifdef ALU_ISSUE_SKID_EN
  logic          r_skid_valid;
  logic [FW-1:0] r_skid_fields;
  logic          w_main_free;

  assign bus.in_ready = !r_skid_valid && !bus.flush;
  assign w_main_free  = !r_out_valid || bus.out_ready;

  // Output register refills from the skid entry first to keep program order
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid   <= 1'b0;
      r_out_fields  <= FIELDS_IDLE;
      r_skid_valid  <= 1'b0;
      r_skid_fields <= FIELDS_IDLE;
    end else if (bus.flush) begin
      r_out_valid   <= 1'b0;
      r_out_fields  <= FIELDS_IDLE;
      r_skid_valid  <= 1'b0;
      r_skid_fields <= FIELDS_IDLE;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_out_valid   <= 1'b1;
        r_out_fields  <= r_skid_fields;
        r_skid_valid  <= 1'b0;
        r_skid_fields <= FIELDS_IDLE;
      end else if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_fields  <= w_dec_fields;
      end else begin
        r_out_valid   <= 1'b0;
        r_out_fields  <= FIELDS_IDLE;
      end
    end else if (w_accept) begin
      r_skid_valid  <= 1'b1;
      r_skid_fields <= w_dec_fields;
    end else begin
      r_skid_valid  <= r_skid_valid;
      r_skid_fields <= r_skid_fields;
    end
  end
`else
  logic w_out_xfer;

  assign bus.in_ready = !bus.flush && (!r_out_valid || bus.out_ready);
  assign w_out_xfer   = r_out_valid && bus.out_ready;

  // Single output register; flush wins over any simultaneous transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid  <= 1'b0;
      r_out_fields <= FIELDS_IDLE;
    end else if (bus.flush) begin
      r_out_valid  <= 1'b0;
      r_out_fields <= FIELDS_IDLE;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_fields <= w_dec_fields;
    end else if (w_out_xfer) begin
      r_out_valid  <= 1'b0;
      r_out_fields <= FIELDS_IDLE;
    end else begin
      r_out_valid  <= r_out_valid;
      r_out_fields <= r_out_fields;
    end
  end
`endif

  assign bus.out_valid = r_out_valid;
  assign {bus.alu_func, bus.alu_src1, bus.alu_src2, bus.br_en, bus.br_inv, bus.rd,
          bus.wb_en, bus.illegal} = r_out_fields;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised self-checking bench for alu_issue_stage against a queue-based
// reference model of the handshake and a mnemonic-level decode model.
module tb_alu_issue_stage;

  typedef struct {
    logic [3:0]  func;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        br;
    logic        inv;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;
  exp_t q[$];

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32), .NOP_FUNC(4'b0000)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] f3_func(input logic [2:0] f3);
    case (f3)
      3'd0:    return 4'd0;
      3'd1:    return 4'd9;
      3'd2:    return 4'd4;
      3'd3:    return 4'd3;
      3'd4:    return 4'd7;
      3'd5:    return 4'd8;
      3'd6:    return 4'd6;
      default: return 4'd5;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii;
    logic [31:0] si;
    logic [31:0] ui;
    logic        writes;
    logic        legal;
    f3     = w[14:12];
    f7     = w[31:25];
    ii     = 32'($signed(w) >>> 20);
    si     = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
    ui     = w & 32'hFFFF_F000;
    writes = 1'b0;
    legal  = 1'b1;
    e      = '{func: 4'd0, s1: a, s2: b, br: 1'b0, inv: 1'b0, rd: 5'd0, wb: 1'b0, ill: 1'b0};
    case (w[6:0])
      7'h33: begin
        writes = 1'b1;
        if (f7 == 7'h00) begin
          e.func = f3_func(f3);
          if (f3 == 3'd1 || f3 == 3'd5) e.s2 = b % 32;
        end else if (f7 == 7'h20 && f3 == 3'd0) e.func = 4'd1;
        else legal = 1'b0;
      end
      7'h13: begin
        writes = 1'b1;
        e.func = f3_func(f3);
        e.s2   = ii;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.s2  = ii % 32;
          legal = (w[30] == 1'b0);
        end
      end
      7'h37: begin writes = 1'b1; e.func = 4'd10; e.s2 = ui; end
      7'h17: begin writes = 1'b1; e.s1 = pc; e.s2 = ui; end
      7'h6F: begin writes = 1'b1; e.s1 = pc; e.s2 = 32'd4; end
      7'h67: begin writes = 1'b1; e.s1 = pc; e.s2 = 32'd4; legal = (f3 == 3'd0); end
      7'h03: begin writes = 1'b1; e.s2 = ii; legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'h23: begin e.s2 = si; legal = (f3 < 3'd3); end
      7'h63: begin
        e.br   = 1'b1;
        e.inv  = f3[0];
        e.func = (f3 < 3'd2) ? 4'd2 : ((f3 < 3'd6) ? 4'd4 : 4'd3);
        legal  = !(f3 == 3'd2 || f3 == 3'd3);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '{func: 4'd0, s1: 32'd0, s2: 32'd0, br: 1'b0, inv: 1'b0, rd: 5'd0, wb: 1'b0, ill: 1'b1};
    end else begin
      e.wb = writes && (w[11:7] != 5'd0);
      e.rd = e.wb ? w[11:7] : 5'd0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [3:0]  k;
    w = $urandom;
    k = 4'($urandom_range(0, 9));
    case (k)
      4'd0: begin
        w[6:0] = 7'h33;
        if ($urandom_range(0, 7) < 5) w[31:25] = 7'h00;
        else if ($urandom_range(0, 1) == 0) w[31:25] = 7'h20;
      end
      4'd1: w[6:0] = 7'h13;
      4'd2: w[6:0] = 7'h37;
      4'd3: w[6:0] = 7'h17;
      4'd4: w[6:0] = 7'h6F;
      4'd5: begin
        w[6:0] = 7'h67;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0;
      end
      4'd6: w[6:0] = 7'h03;
      4'd7: w[6:0] = 7'h23;
      4'd8: w[6:0] = 7'h63;
      default: w = w;
    endcase
    return w;
  endfunction

  task automatic check_outputs();
    if (q.size() > 0) begin
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("alu_func",  32'(bus.alu_func),  32'(q[0].func));
      chk("alu_src1",  bus.alu_src1,       q[0].s1);
      chk("alu_src2",  bus.alu_src2,       q[0].s2);
      chk("br_en",     32'(bus.br_en),     32'(q[0].br));
      chk("br_inv",    32'(bus.br_inv),    32'(q[0].inv));
      chk("rd",        32'(bus.rd),        32'(q[0].rd));
      chk("wb_en",     32'(bus.wb_en),     32'(q[0].wb));
      chk("illegal",   32'(bus.illegal),   32'(q[0].ill));
    end else begin
      chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
      chk("func_idle",      32'(bus.alu_func),  32'd0);
      chk("wb_idle",        32'(bus.wb_en),     32'd0);
      chk("br_idle",        32'(bus.br_en),     32'd0);
      chk("illegal_idle",   32'(bus.illegal),   32'd0);
    end
  endtask

  // Called at posedge+1: drive, check in_ready at negedge, update model, check after next edge
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic fl, input logic orr);
    logic exp_rdy;
    bus.in_valid    = v;
    bus.in_instr    = ins;
    bus.in_pc       = pc;
    bus.in_rs1_data = r1;
    bus.in_rs2_data = r2;
    bus.flush       = fl;
    bus.out_ready   = orr;
    @(negedge clk);
`ifdef ALU_ISSUE_SKID_EN
    exp_rdy = !fl && (q.size() < 2);
`else
    exp_rdy = !fl && ((q.size() == 0) || orr);
`endif
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && orr) void'(q.pop_front());
      if (v && exp_rdy) q.push_back(ref_decode(ins, pc, r1, r2));
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rstn         = 1'b0;
    #2;
    q.delete();
    chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
    check_outputs();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rstn            = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_instr    = 32'd0;
    bus.in_pc       = 32'd0;
    bus.in_rs1_data = 32'd0;
    bus.in_rs2_data = 32'd0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_src1", bus.alu_src1, 32'd0);
    chk("rst_src2", bus.alu_src2, 32'd0);
    chk("rst_rd",   32'(bus.rd),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // addi x5,x0,7
    step(1'b1, 32'h0070_0293, 32'h0000_1000, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_func",  32'(bus.alu_func),  32'd0);
    chk("addi_src1",  bus.alu_src1,       32'd0);
    chk("addi_src2",  bus.alu_src2,       32'd7);
    chk("addi_rd",    32'(bus.rd),        32'd5);
    chk("addi_wb",    32'(bus.wb_en),     32'd1);

    // slli x1,x2 with imm[11:0]=0x023
    step(1'b1, 32'h0231_1093, 32'h0000_1004, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
    chk("slli_func", 32'(bus.alu_func), 32'd9);
    chk("slli_src2", bus.alu_src2,      32'd3);

    // srai x1,x1,2
    step(1'b1, 32'h4020_D093, 32'h0000_1008, 32'h0000_00F0, 32'd0, 1'b0, 1'b1);
    chk("srai_illegal", 32'(bus.illegal), 32'd1);
    chk("srai_wb",      32'(bus.wb_en),   32'd0);

    // bge x1,x2
    step(1'b1, 32'h0020_D063, 32'h0000_100C, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    chk("bge_func", 32'(bus.alu_func), 32'd4);
    chk("bge_br",   32'(bus.br_en),    32'd1);
    chk("bge_inv",  32'(bus.br_inv),   32'd1);
    chk("bge_src1", bus.alu_src1,      32'hFFFF_FFFF);

    // Backpressure: addi x6,x0,0x55 held, then add x7,x1,x2 behind it
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h0550_0313, 32'h0000_2000, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0020_83B3, 32'h0000_2004, 32'd10, 32'd20, 1'b0, 1'b0);
      chk("bp_hold_src2", bus.alu_src2, 32'h55);
      chk("bp_hold_rd",   32'(bus.rd),  32'd6);
    end
    step(1'b1, 32'h0020_83B3, 32'h0000_2004, 32'd10, 32'd20, 1'b0, 1'b1);
    chk("bp_second_rd", 32'(bus.rd), 32'd7);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Flush with simultaneous in and out transfer
    step(1'b1, 32'h0550_0313, 32'h0000_3000, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h0020_83B3, 32'h0000_3004, 32'd1, 32'd2, 1'b1, 1'b1);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    step(1'b1, 32'h1234_51B7, 32'h0000_3008, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("lui_func", 32'(bus.alu_func), 32'd10);
    chk("lui_src2", bus.alu_src2,      32'h1234_5000);
    chk("lui_rd",   32'(bus.rd),       32'd3);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom & 32'hFFFF_FFFC),
           $urandom, $urandom, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    // Reset while an instruction is held
    step(1'b1, 32'h0550_0313, 32'h0000_4000, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    do_reset();
    check_outputs();
    step(1'b1, 32'h0070_0293, 32'h0000_5000, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("post_rst_src2", bus.alu_src2, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
